// File: rtl/muldiv_iter_unit.sv
// Iterative RISC-V M-extension execute unit: shift-add multiplier and restoring
// divider sharing one accumulator, with a one-cycle path for div-by-zero and overflow.
module muldiv_iter_unit #(
  parameter int XLEN    = 32,
  parameter int MUL_BPC = 4,
  parameter int DIV_BPC = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            ready,
  output logic            busy,
  output logic [XLEN-1:0] result,
  output logic            div_by_zero
);

  localparam int MUL_ITERS = XLEN / MUL_BPC;
  localparam int DIV_ITERS = XLEN / DIV_BPC;
  localparam int CW        = $clog2(XLEN) + 1;

  localparam logic [CW-1:0]     MUL_LAST = CW'(MUL_ITERS - 1);
  localparam logic [CW-1:0]     DIV_LAST = CW'(DIV_ITERS - 1);
  localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ZERO_X   = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ONES_X   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [2*XLEN-1:0] ZERO_P   = {(2*XLEN){1'b0}};
  localparam logic [2*XLEN-1:0] ONE_P    = {{(2*XLEN-1){1'b0}}, 1'b1};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL   = 3'd1,
    S_DIV   = 3'd2,
    S_FIXUP = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return (~v) + ONE_X;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_p(input logic [2*XLEN-1:0] v);
    return (~v) + ONE_P;
  endfunction

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic is_signed);
    if (is_signed && v[XLEN-1]) begin
      return neg_x(v);
    end else begin
      return v;
    end
  endfunction

  state_t            state_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        op_r;
  logic              neg_r;
  logic              dbz_r;
  // opa_r: shifting multiplicand, or divisor in the low half during DIV.
  // opb_r: multiplier slices shift out, or dividend bits shift out as quotient bits shift in.
  // acc_r: product, or the XLEN+1 bit partial remainder in its low bits.
  logic [2*XLEN-1:0] opa_r;
  logic [XLEN-1:0]   opb_r;
  logic [2*XLEN-1:0] acc_r;

  logic              a_signed_s;
  logic              b_signed_s;
  logic              a_neg_s;
  logic              b_neg_s;
  logic              div_zero_s;
  logic              ovf_s;
  logic              neg_start_s;
  logic [XLEN-1:0]   mag_a_s;
  logic [XLEN-1:0]   mag_b_s;
  logic [XLEN-1:0]   special_res_s;
  logic [2*XLEN-1:0] acc_mul_s;
  logic [XLEN:0]     div_rem_s;
  logic [XLEN-1:0]   div_quo_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_res_s;

  // Operand decode at accept: signedness, magnitudes and special-case detection.
  always_comb begin
    a_signed_s    = 1'b0;
    b_signed_s    = 1'b0;
    special_res_s = ZERO_X;
    case (op)
      OP_MULH:        begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      OP_MULHSU:      begin a_signed_s = 1'b1; b_signed_s = 1'b0; end
      OP_DIV, OP_REM: begin a_signed_s = 1'b1; b_signed_s = 1'b1; end
      default:        begin a_signed_s = 1'b0; b_signed_s = 1'b0; end
    endcase
    a_neg_s    = a_signed_s & rs1[XLEN-1];
    b_neg_s    = b_signed_s & rs2[XLEN-1];
    mag_a_s    = mag(rs1, a_signed_s);
    mag_b_s    = mag(rs2, b_signed_s);
    div_zero_s = op[2] && (rs2 == ZERO_X);
    ovf_s      = ((op == OP_DIV) || (op == OP_REM)) && (rs1 == MOST_NEG) && (rs2 == ONES_X);
    // Remainders follow the dividend sign; products and quotients follow the sign product.
    if (op[2] && op[1]) begin
      neg_start_s = a_neg_s;
    end else begin
      neg_start_s = a_neg_s ^ b_neg_s;
    end
    if (div_zero_s) begin
      special_res_s = op[1] ? rs1 : ONES_X;
    end else if (ovf_s) begin
      special_res_s = op[1] ? ZERO_X : MOST_NEG;
    end else begin
      special_res_s = ZERO_X;
    end
  end

  // One multiply step: add the shifted multiplicand times the low MUL_BPC multiplier bits.
  always_comb begin
    acc_mul_s = acc_r + (opa_r * {{(2*XLEN-MUL_BPC){1'b0}}, opb_r[MUL_BPC-1:0]});
  end

  // DIV_BPC restoring-division steps per cycle.
  always_comb begin
    div_rem_s = acc_r[XLEN:0];
    div_quo_s = opb_r;
    for (int i = 0; i < DIV_BPC; i++) begin
      div_rem_s = {div_rem_s[XLEN-1:0], div_quo_s[XLEN-1]};
      div_quo_s = {div_quo_s[XLEN-2:0], 1'b0};
      if (div_rem_s >= {1'b0, opa_r[XLEN-1:0]}) begin
        div_rem_s    = div_rem_s - {1'b0, opa_r[XLEN-1:0]};
        div_quo_s[0] = 1'b1;
      end else begin
        div_quo_s[0] = 1'b0;
      end
    end
  end

  // Sign fix-up and result selection for the FIXUP cycle.
  always_comb begin
    prod_s    = neg_r ? neg_p(acc_r) : acc_r;
    quo_s     = neg_r ? neg_x(opb_r) : opb_r;
    rem_s     = neg_r ? neg_x(acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
    fix_res_s = ZERO_X;
    case (op_r)
      OP_MUL:                      fix_res_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res_s = quo_s;
      OP_REM, OP_REMU:             fix_res_s = rem_s;
      default:                     fix_res_s = ZERO_X;
    endcase
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      cnt_r       <= {CW{1'b0}};
      op_r        <= 3'b000;
      neg_r       <= 1'b0;
      dbz_r       <= 1'b0;
      opa_r       <= ZERO_P;
      opb_r       <= ZERO_X;
      acc_r       <= ZERO_P;
      ready       <= 1'b0;
      busy        <= 1'b0;
      result      <= ZERO_X;
      div_by_zero <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (valid) begin
            op_r  <= op;
            cnt_r <= {CW{1'b0}};
            neg_r <= neg_start_s;
            dbz_r <= div_zero_s;
            acc_r <= ZERO_P;
            busy  <= 1'b1;
            if (op[2]) begin
              opa_r <= {ZERO_X, mag_b_s};
              opb_r <= mag_a_s;
            end else begin
              opa_r <= {ZERO_X, mag_a_s};
              opb_r <= mag_b_s;
            end
            if (div_zero_s || ovf_s) begin
              result  <= special_res_s;
              state_r <= S_DONE;
            end else if (op[2]) begin
              state_r <= S_DIV;
            end else begin
              state_r <= S_MUL;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_MUL: begin
          acc_r <= acc_mul_s;
          opa_r <= opa_r << MUL_BPC;
          opb_r <= opb_r >> MUL_BPC;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == MUL_LAST) begin
            state_r <= S_FIXUP;
          end else begin
            state_r <= S_MUL;
          end
        end
        S_DIV: begin
          acc_r <= {{(XLEN-1){1'b0}}, div_rem_s};
          opb_r <= div_quo_s;
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == DIV_LAST) begin
            state_r <= S_FIXUP;
          end else begin
            state_r <= S_DIV;
          end
        end
        S_FIXUP: begin
          result  <= fix_res_s;
          state_r <= S_DONE;
        end
        S_DONE: begin
          ready       <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= dbz_r;
          state_r     <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Scoreboard bench for muldiv_iter_unit: default 32-bit instance plus a
// 16-bit instance with MUL_BPC=2, DIV_BPC=2.
module tb_muldiv_iter_unit;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          lat;
  } exp_t;

  logic        clk;
  logic        resetn;
  logic        valid, valid16;
  logic [2:0]  op, op16;
  logic [31:0] rs1, rs2;
  logic [15:0] a16, b16;
  logic        ready, busy, dbz;
  logic        ready16, busy16, dbz16;
  logic [31:0] result;
  logic [15:0] result16;

  int   checks = 0;
  int   fails  = 0;
  exp_t exp_q[$];

  muldiv_iter_unit dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .rs1(rs1), .rs2(rs2),
    .ready(ready), .busy(busy), .result(result), .div_by_zero(dbz)
  );

  muldiv_iter_unit #(.XLEN(16), .MUL_BPC(2), .DIV_BPC(2)) dut16 (
    .clk(clk), .resetn(resetn), .valid(valid16), .op(op16), .rs1(a16), .rs2(b16),
    .ready(ready16), .busy(busy16), .result(result16), .div_by_zero(dbz16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model using 64-bit integer arithmetic at width w.
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b, input int w);
    longint unsigned mask, ua, ub, up;
    longint sa, sb, sp, mn;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    sa   = a[w-1] ? longint'(ua) - (longint'(1) << w) : longint'(ua);
    sb   = b[w-1] ? longint'(ub) - (longint'(1) << w) : longint'(ub);
    mn   = -(longint'(1) << (w - 1));
    up   = 64'd0;
    case (o)
      3'b000: up = ua * ub;
      3'b001: begin sp = sa * sb; up = sp >>> w; end
      3'b010: begin sp = sa * longint'(ub); up = sp >>> w; end
      3'b011: up = (ua * ub) >> w;
      3'b100: begin
        if (ub == 0) up = mask;
        else if (sa == mn && sb == -1) up = ua;
        else begin sp = sa / sb; up = sp; end
      end
      3'b101: up = (ub == 0) ? mask : ua / ub;
      3'b110: begin
        if (ub == 0) up = ua;
        else if (sa == mn && sb == -1) up = 64'd0;
        else begin sp = sa % sb; up = sp; end
      end
      default: up = (ub == 0) ? ua : ua % ub;
    endcase
    up = up & mask;
    return up[31:0];
  endfunction

  // Push the expectation, drive the request and pass the accept edge.
  task automatic issue(input bit w16, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit hold);
    exp_t e;
    int w, mb, db;
    logic [31:0] am, bm, mn;
    w  = w16 ? 16 : 32;
    mb = w16 ? 2 : 4;
    db = w16 ? 2 : 1;
    am = w16 ? {16'd0, a[15:0]} : a;
    bm = w16 ? {16'd0, b[15:0]} : b;
    mn = w16 ? 32'h0000_8000 : 32'h8000_0000;
    e.res = model(o, a, b, w);
    e.dbz = o[2] && (bm == 32'd0);
    if (o[2] && ((bm == 32'd0) || (!o[0] && am == mn && bm == (w16 ? 32'h0000_FFFF : 32'hFFFF_FFFF))))
      e.lat = 1;
    else if (o[2])
      e.lat = w / db + 2;
    else
      e.lat = w / mb + 2;
    exp_q.push_back(e);
    if (w16) begin valid16 = 1'b1; op16 = o; a16 = a[15:0]; b16 = b[15:0]; end
    else begin valid = 1'b1; op = o; rs1 = a; rs2 = b; end
    @(posedge clk); #1;
    if (!hold) begin
      if (w16) begin valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); end
      else begin valid = 1'b0; rs1 = $urandom; rs2 = $urandom; end
    end
  endtask

  // Count cycles from the accept edge until ready; bounded at 200 cycles.
  task automatic wait_ready(input bit w16, output int n, output bit busy_ok);
    n = 0;
    busy_ok = 1'b1;
    while (!(w16 ? ready16 : ready) && n < 200) begin
      if (!(w16 ? busy16 : busy)) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    if (w16 ? busy16 : busy) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b0; valid16 = 1'b0;
    op = 3'b000; op16 = 3'b000; rs1 = 32'd0; rs2 = 32'd0; a16 = 16'd0; b16 = 16'd0;
    #22 resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({ready, busy, dbz, result} !== {3'b000, 32'd0}) begin
      fails++; $display("FAIL reset32 got r/b/z/res=%b%b%b/%h exp 000/0", ready, busy, dbz, result);
    end
    checks++;
    if ({ready16, busy16, dbz16, result16} !== {3'b000, 16'd0}) begin
      fails++; $display("FAIL reset16 got r/b/z/res=%b%b%b/%h exp 000/0", ready16, busy16, dbz16, result16);
    end
  endtask

  task automatic test_mul();
    vec_t v[6] = '{
      '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD}, '{3'b001, 32'h8000_0000, 32'h8000_0000},
      '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
      '{3'b001, 32'h1234_5678, 32'hF00D_CAFE}, '{3'b010, 32'h8765_4321, 32'hDEAD_BEEF}};
    exp_t e; int n; bit bok;
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, v[i].op, v[i].a, v[i].b, 1'b0);
      wait_ready(1'b0, n, bok);
      e = exp_q.pop_front();
      checks += 3;
      if (result !== e.res) begin fails++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, result, e.res); end
      if (n !== e.lat) begin fails++; $display("FAIL mul_latency[%0d] got=%0d exp=%0d", i, n, e.lat); end
      if ({dbz, bok} !== {e.dbz, 1'b1}) begin fails++; $display("FAIL mul_dbz_busy[%0d] got=%b%b exp=%b1", i, dbz, bok, e.dbz); end
    end
  endtask

  task automatic test_div();
    vec_t v[7] = '{
      '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002}, '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002},
      '{3'b101, 32'd100, 32'd7}, '{3'b111, 32'd100, 32'd7},
      '{3'b100, 32'h7FFF_FFFF, 32'hFFFF_FFFD}, '{3'b110, 32'h8000_0001, 32'h0000_0010},
      '{3'b101, 32'hFFFF_FFFF, 32'h0000_0003}};
    exp_t e; int n; bit bok;
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, v[i].op, v[i].a, v[i].b, 1'b0);
      wait_ready(1'b0, n, bok);
      e = exp_q.pop_front();
      checks += 3;
      if (result !== e.res) begin fails++; $display("FAIL div_result[%0d] got=%h exp=%h", i, result, e.res); end
      if (n !== e.lat) begin fails++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, n, e.lat); end
      if ({dbz, bok} !== {e.dbz, 1'b1}) begin fails++; $display("FAIL div_dbz_busy[%0d] got=%b%b exp=%b1", i, dbz, bok, e.dbz); end
    end
  endtask

  task automatic test_special();
    vec_t v[7] = '{
      '{3'b101, 32'd5, 32'd0}, '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF},
      '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF}, '{3'b110, 32'hDEAD_BEEF, 32'd0},
      '{3'b000, 32'd3, 32'd5}, '{3'b111, 32'h1234_5678, 32'd0}, '{3'b100, 32'hFFFF_FFF0, 32'd0}};
    exp_t e; int n; bit bok;
    for (int i = 0; i < 7; i++) begin
      issue(1'b0, v[i].op, v[i].a, v[i].b, 1'b0);
      wait_ready(1'b0, n, bok);
      e = exp_q.pop_front();
      checks += 3;
      if (result !== e.res) begin fails++; $display("FAIL special_result[%0d] got=%h exp=%h", i, result, e.res); end
      if (n !== e.lat) begin fails++; $display("FAIL special_latency[%0d] got=%0d exp=%0d", i, n, e.lat); end
      if ({dbz, bok} !== {e.dbz, 1'b1}) begin fails++; $display("FAIL special_dbz_busy[%0d] got=%b%b exp=%b1", i, dbz, bok, e.dbz); end
    end
  endtask

  task automatic test_reset_mid_op();
    exp_t e; int n; bit bok; int seen;
    issue(1'b0, 3'b100, 32'h0001_0000, 32'd3, 1'b0);
    void'(exp_q.pop_front());
    repeat (11) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    checks++;
    if ({ready, busy, result} !== {2'b00, 32'd0}) begin
      fails++; $display("FAIL abort_state got r/b/res=%b%b/%h exp 00/0", ready, busy, result);
    end
    repeat (2) begin @(posedge clk); #1; end
    resetn = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready || busy) seen++;
    end
    checks++;
    if (seen !== 0) begin fails++; $display("FAIL abort_no_ready got=%0d active cycles exp=0", seen); end
    issue(1'b0, 3'b000, 32'd3, 32'd4, 1'b0);
    wait_ready(1'b0, n, bok);
    e = exp_q.pop_front();
    checks += 2;
    if (result !== 32'd12 || result !== e.res) begin fails++; $display("FAIL post_abort_mul got=%h exp=%h", result, 32'd12); end
    if (n !== 10 || !bok) begin fails++; $display("FAIL post_abort_latency got=%0d/%b exp=10/1", n, bok); end
  endtask

  task automatic test_back_to_back();
    exp_t e; int n; bit bok; int extra;
    issue(1'b0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_ready(1'b0, n, bok);
    e = exp_q.pop_front();
    checks += 2;
    if (result !== e.res) begin fails++; $display("FAIL b2b_first got=%h exp=%h", result, e.res); end
    if (n !== e.lat) begin fails++; $display("FAIL b2b_first_latency got=%0d exp=%0d", n, e.lat); end
    rs1 = 32'h0001_0000; rs2 = 32'h0003_0000;
    e.res = model(3'b011, rs1, rs2, 32); e.dbz = 1'b0; e.lat = 10;
    exp_q.push_back(e);
    @(posedge clk); #1;
    checks++;
    if ({busy, ready} !== 2'b10) begin fails++; $display("FAIL b2b_accept got busy/ready=%b%b exp=10", busy, ready); end
    valid = 1'b0;
    wait_ready(1'b0, n, bok);
    e = exp_q.pop_front();
    checks += 2;
    if (result !== e.res) begin fails++; $display("FAIL b2b_second got=%h exp=%h", result, e.res); end
    if (n !== e.lat || !bok) begin fails++; $display("FAIL b2b_second_latency got=%0d/%b exp=%0d/1", n, bok, e.lat); end
    extra = 0;
    for (int i = 0; i < 15; i++) begin @(posedge clk); #1; if (busy) extra++; end
    checks++;
    if (extra !== 0) begin fails++; $display("FAIL b2b_no_replay got=%0d busy cycles exp=0", extra); end
  endtask

  task automatic test_xlen16();
    vec_t v[5] = '{
      '{3'b000, 32'h0000_0123, 32'h0000_0456}, '{3'b100, 32'h0000_8000, 32'h0000_FFFF},
      '{3'b100, 32'h0000_FF9C, 32'h0000_0007}, '{3'b111, 32'h0000_ABCD, 32'h0000_0013},
      '{3'b001, 32'h0000_8001, 32'h0000_7FFF}};
    exp_t e; int n; bit bok;
    for (int i = 0; i < 5; i++) begin
      issue(1'b1, v[i].op, v[i].a, v[i].b, 1'b0);
      wait_ready(1'b1, n, bok);
      e = exp_q.pop_front();
      checks += 3;
      if ({16'd0, result16} !== e.res) begin fails++; $display("FAIL x16_result[%0d] got=%h exp=%h", i, result16, e.res); end
      if (n !== e.lat) begin fails++; $display("FAIL x16_latency[%0d] got=%0d exp=%0d", i, n, e.lat); end
      if ({dbz16, bok} !== {e.dbz, 1'b1}) begin fails++; $display("FAIL x16_dbz_busy[%0d] got=%b%b exp=%b1", i, dbz16, bok, e.dbz); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_reset_mid_op();
    test_back_to_back();
    test_xlen16();
    checks++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
Unified, parametrised iterative M-extension execute unit for the multicycle core. It replaces the separate multiplier and divider behind a single valid/ready handshake. The unit accepts RISC-V funct3 encodings for all eight MUL/DIV/REM ops. Bits-per-cycle and data width are configurable, and fast paths short-circuit divide-by-zero and signed overflow.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8.
MUL_BPC, 4, multiplier bits retired per iteration; power of two dividing XLEN.
DIV_BPC, 1, quotient bits retired per iteration; 1, 2 or 4, dividing XLEN.

Ports:
clk  input  1  core clock; all state on rising edge.
resetn  input  1  asynchronous, active-low reset.
valid  input  1  start request, level; sampled only in IDLE.
op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
rs1  input  XLEN  operand A (multiplicand / dividend).
rs2  input  XLEN  operand B (multiplier / divisor).
ready  output  1  one-cycle completion pulse; result valid in this cycle and held after.
busy  output  1  high from accept edge until the cycle before ready.
result  output  XLEN  registered result.
div_by_zero  output  1  registered; set with ready when a DIV/DIVU/REM/REMU had rs2==0, else cleared at ready.

Behaviour:
- Reset (async, resetn=0): state=IDLE; ready=0, busy=0, result=0, div_by_zero=0; iteration counter and internal accumulators = 0. Reset mid-operation aborts with no ready pulse.
- States: IDLE, MUL, DIV, FIXUP, DONE.
- IDLE & valid=1 at edge k (accept edge):
  - latch op, |rs1|, |rs2| (absolute value only for signed operands per op), result sign bits; counter=0; busy=1.
  - next state selection:
    - divide op with rs2==0, or DIV/REM with rs1=most-negative and rs2=all-ones: go to DONE (special path).
    - other multiply ops: go to MUL.
    - other divide ops: go to DIV.
- MUL:
  - each cycle adds (multiplicand << shift) × MUL_BPC-bit multiplier slice into a 2·XLEN accumulator.
  - after XLEN/MUL_BPC cycles, go to FIXUP.
- DIV:
  - restoring division, DIV_BPC quotient bits per cycle, remainder width XLEN+1.
  - after XLEN/DIV_BPC cycles, go to FIXUP.
- FIXUP (1 cycle):
  - conditional two's-complement negation of product, quotient or remainder.
  - select low/high product half, or quotient/remainder.
  - write result, go to DONE.
- DONE (1 cycle): ready=1, busy=0, go to IDLE.
- Latency L (ready high between edges k+L and k+L+1):
  - MUL ops: L = XLEN/MUL_BPC + 2 (10 for defaults).
  - DIV ops: L = XLEN/DIV_BPC + 2 (34 for defaults).
  - special path: L = 1.
  - L is data-independent except for the special path.
- Sign rules:
  - MULH: signed×signed. MULHSU: rs1 signed, rs2 unsigned. MULHU/MUL: unsigned core; MUL low half is sign-agnostic.
  - Quotient negated iff operand signs differ (signed ops).
  - Remainder takes dividend sign.
- Special results:
  - divide-by-zero: DIV/DIVU → all-ones; REM/REMU → rs1; div_by_zero=1.
  - signed overflow: DIV → most-negative; REM → 0; div_by_zero=0.
- Handshake:
  - valid is ignored while not IDLE; operands may change freely after the accept edge.
  - If valid is still high in the IDLE cycle after DONE, a new op is accepted. The control unit must drop valid in the ready cycle to avoid a replay.
- result holds its last value until the next FIXUP or special-path write. Multiply ops clear div_by_zero at ready.

Test Plan:
- MUL rs1=0x0000_0007, rs2=0xFFFF_FFFD → ready at L=10, result=0xFFFF_FFEB, div_by_zero=0.
- MULH rs1=rs2=0x8000_0000 → result 0x4000_0000. MULHSU rs1=0xFFFF_FFFF, rs2=0xFFFF_FFFF → 0xFFFF_FFFF. MULHU same operands → 0xFFFF_FFFE.
- DIV rs1=0xFFFF_FFF9 (-7), rs2=2 → ready at L=34, result 0xFFFF_FFFD (-3). REM same operands → 0xFFFF_FFFF (-1). DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU rs1=5, rs2=0 → ready at L=1, result 0xFFFF_FFFF, div_by_zero=1. REM rs1=0x8000_0000, rs2=0xFFFF_FFFF → L=1, result 0, div_by_zero=0.
- Assert resetn=0 at cycle 12 of a DIV; release → no ready pulse, result=0, busy=0. A following MUL 3×4 completes with result 12.
- Hold valid high across ready with op=MULHU → exactly one new accept in the cycle after DONE, busy back to 1. Rerun the bench with XLEN=16, MUL_BPC=2, DIV_BPC=2: MUL L=10, DIV L=10, DIV 0x8000/0xFFFF → 0x8000.
